// File: rtl/load_store_unit_if.sv
// Memory-side bus bundle for the load/store unit.
// valid/ready handshake; master = LSU, slave = memory.
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata, mem_ready, mem_err
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata, mem_ready, mem_err
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns a core load/store into one word-aligned bus access,
// steering store lanes, extending load data and flagging faults.
// Ports: clk, rst_n (sync, active-low); core side Req/IsStore/Funct3/Addr/
// StoreData in, Stall/Done/LoadData/Misaligned/AccessErr out; memory side
// through load_store_unit_if.master (mem_*).
// Optional: define LSU_TIMEOUT_EN to abort a bus access after TIMEOUT_CYCLES.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Req,
    input  logic        IsStore,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] StoreData,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] LoadData,
    output logic        Misaligned,
    output logic        AccessErr,
    load_store_unit_if.master mem
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic        isStoreQ;
    logic [2:0]  funct3Q;
    logic [1:0]  offQ;

    logic        illegal;
    logic        misal;
    logic [31:0] wdataNext;
    logic [3:0]  wstrbNext;
    logic [31:0] shifted;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadExt;

`ifdef LSU_TIMEOUT_EN
    localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] toCnt;
    logic            toHit;
    assign toHit = (toCnt == CntW'(TIMEOUT_CYCLES - 1));
`endif

    assign Stall = Req & ~Done;

    // Funct3 011 and 11x are never legal; unsigned forms only exist for loads.
    assign illegal = (Funct3 == 3'b011)
                   | (Funct3[2:1] == 2'b11)
                   | (IsStore & Funct3[2]);

    assign misal = ((Funct3[1:0] == 2'b01) & Addr[0])
                 | ((Funct3[1:0] == 2'b10) & (|Addr[1:0]));

    always_comb begin
        wdataNext = StoreData;
        wstrbNext = 4'b1111;
        unique case (1'b1)
            (Funct3[1:0] == 2'b00): begin
                wdataNext = {4{StoreData[7:0]}};
                wstrbNext = 4'b0001 << Addr[1:0];
            end
            (Funct3[1:0] == 2'b01): begin
                wdataNext = {2{StoreData[15:0]}};
                wstrbNext = 4'b0011 << Addr[1:0];
            end
            default: ;
        endcase
        if (!IsStore) begin
            wstrbNext = 4'b0000;
        end
    end

    assign shifted = mem.mem_rdata >> {offQ, 3'b000};
    assign byteSel = shifted[7:0];
    assign halfSel = offQ[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        loadExt = mem.mem_rdata;
        unique case (1'b1)
            (funct3Q == 3'b000): loadExt = {{24{byteSel[7]}}, byteSel};
            (funct3Q == 3'b001): loadExt = {{16{halfSel[15]}}, halfSel};
            (funct3Q == 3'b100): loadExt = {24'd0, byteSel};
            (funct3Q == 3'b101): loadExt = {16'd0, halfSel};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            isStoreQ      <= 1'b0;
            funct3Q       <= 3'd0;
            offQ          <= 2'd0;
            Done          <= 1'b0;
            LoadData      <= 32'd0;
            Misaligned    <= 1'b0;
            AccessErr     <= 1'b0;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            mem.mem_wstrb <= 4'd0;
`ifdef LSU_TIMEOUT_EN
            toCnt         <= '0;
`endif
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Req) begin
                        isStoreQ <= IsStore;
                        funct3Q  <= Funct3;
                        offQ     <= Addr[1:0];
                        if (illegal) begin
                            state      <= RESP;
                            Done       <= 1'b1;
                            AccessErr  <= 1'b1;
                            Misaligned <= 1'b0;
                            LoadData   <= 32'd0;
                        end else if (misal) begin
                            state      <= RESP;
                            Done       <= 1'b1;
                            AccessErr  <= 1'b0;
                            Misaligned <= 1'b1;
                            LoadData   <= 32'd0;
                        end else begin
                            state         <= BUS;
                            mem.mem_valid <= 1'b1;
                            mem.mem_we    <= IsStore;
                            mem.mem_addr  <= {Addr[31:2], 2'b00};
                            mem.mem_wdata <= wdataNext;
                            mem.mem_wstrb <= wstrbNext;
`ifdef LSU_TIMEOUT_EN
                            toCnt         <= '0;
`endif
                        end
                    end
                end
                BUS: begin
                    if (mem.mem_ready) begin
                        state         <= RESP;
                        mem.mem_valid <= 1'b0;
                        Done          <= 1'b1;
                        Misaligned    <= 1'b0;
                        AccessErr     <= mem.mem_err;
                        LoadData      <= (mem.mem_err | isStoreQ) ? 32'd0 : loadExt;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (toHit) begin
                        state         <= RESP;
                        mem.mem_valid <= 1'b0;
                        Done          <= 1'b1;
                        Misaligned    <= 1'b0;
                        AccessErr     <= 1'b1;
                        LoadData      <= 32'd0;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
`endif
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
